// File: rtl/axis_pkt_arbiter_sva.sv
// Property harness bound into every axis_pkt_arbiter.
// It checks slave-side ready rules, the grant lock and master-side stability.
module axis_pkt_arbiter_sva #(
  parameter int NIN = 4,
  parameter int DW  = 32,
  parameter int UW  = 1
) (
  input logic                   i_aclk,
  input logic                   i_areset,
  input logic [NIN-1:0]         s_tvalid,
  input logic [NIN-1:0]         s_tready,
  input logic [NIN-1:0]         s_tlast,
  input logic                   m_tvalid,
  input logic                   m_tready,
  input logic [DW-1:0]          m_tdata,
  input logic                   m_tlast,
  input logic [UW-1:0]          m_tuser,
  input logic [$clog2(NIN)-1:0] o_grant,
  input logic                   o_busy
);
  localparam int GW = $clog2(NIN);

  a_rdy_onehot0: assert property (@(posedge i_aclk) disable iff (i_areset)
    $onehot0(s_tready));

  a_grant_locked: assert property (@(posedge i_aclk) disable iff (i_areset)
    (o_busy && !(|(s_tvalid & s_tready & s_tlast))) |=> (o_busy && $stable(o_grant)));

  for (genvar k = 0; k < NIN; k++) begin : g_slv
    a_rdy_only_granted: assert property (@(posedge i_aclk) disable iff (i_areset)
      s_tready[k] |-> (o_busy && o_grant == GW'(k)));
    a_last_ends_pkt: assert property (@(posedge i_aclk) disable iff (i_areset)
      (s_tvalid[k] && s_tready[k] && s_tlast[k]) |=> !o_busy);
  end

  a_m_hold: assert property (@(posedge i_aclk) disable iff (i_areset)
    (m_tvalid && !m_tready) |=> (m_tvalid && $stable(m_tdata) && $stable(m_tlast) && $stable(m_tuser)));
endmodule

bind axis_pkt_arbiter axis_pkt_arbiter_sva #(.NIN(NIN), .DW(DW), .UW(UW)) u_sva (
  .i_aclk   (i_aclk),
  .i_areset (i_areset),
  .s_tvalid (s_tvalid),
  .s_tready (s_tready),
  .s_tlast  (s_tlast),
  .m_tvalid (m_tvalid),
  .m_tready (m_tready),
  .m_tdata  (m_tdata),
  .m_tlast  (m_tlast),
  .m_tuser  (m_tuser),
  .o_grant  (o_grant),
  .o_busy   (o_busy)
);

// File: rtl/axis_rr_pick.sv
// Round-robin picker: the lowest requesting index strictly above i_last.
// If no index above i_last is requesting, the search wraps to the lowest requesting index.
module axis_rr_pick #(
  parameter int NIN = 4
) (
  input  logic [NIN-1:0]         i_req,
  input  logic [$clog2(NIN)-1:0] i_last,
  output logic [$clog2(NIN)-1:0] o_next,
  output logic                   o_any
);
  localparam int GW = $clog2(NIN);

  logic [GW-1:0] w_lo;
  logic [GW-1:0] w_hi;
  logic          w_has_hi;

  // Descending scan: the last hit wins, so both candidates end up as the lowest matching index.
  always_comb begin
    w_lo     = i_last;
    w_hi     = i_last;
    w_has_hi = 1'b0;
    for (int i = NIN - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        w_lo = GW'(i);
        if (i > int'(i_last)) begin
          w_hi     = GW'(i);
          w_has_hi = 1'b1;
        end
      end
    end
  end

  assign o_next = w_has_hi ? w_hi : w_lo;
  assign o_any  = |i_req;
endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin AXI-Stream arbiter. It uses one arbitration bubble per packet.
// The master stream is driven from a single registered output slot.
module axis_pkt_arbiter #(
  parameter int NIN = 4,
  parameter int DW  = 32,
  parameter int UW  = 1
) (
  input  logic                     i_aclk,
  input  logic                     i_areset,
  input  logic [NIN-1:0]           s_tvalid,
  output logic [NIN-1:0]           s_tready,
  input  logic [NIN*DW-1:0]        s_tdata,
  input  logic [NIN-1:0]           s_tlast,
  input  logic [NIN*UW-1:0]        s_tuser,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [DW-1:0]            m_tdata,
  output logic                     m_tlast,
  output logic [UW-1:0]            m_tuser,
  output logic [$clog2(NIN)-1:0]   o_grant,
  output logic                     o_busy
);
  localparam int GW = $clog2(NIN);

  typedef enum logic {ST_IDLE = 1'b0, ST_PACKET = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [GW-1:0] r_grant;
  logic [GW-1:0] w_pick;
  logic          w_any;
  logic          w_out_free;
  logic          w_accept;
  logic [DW-1:0] w_sel_data;
  logic          w_sel_last;
  logic [UW-1:0] w_sel_user;

  axis_rr_pick #(.NIN(NIN)) u_pick (
    .i_req  (s_tvalid),
    .i_last (r_grant),
    .o_next (w_pick),
    .o_any  (w_any)
  );

  // The output slot can take a beat when it is empty or is being drained this cycle.
  assign w_out_free = !m_tvalid || m_tready;
  assign w_sel_data = s_tdata[int'(r_grant)*DW +: DW];
  assign w_sel_last = s_tlast[r_grant];
  assign w_sel_user = s_tuser[int'(r_grant)*UW +: UW];
  assign w_accept   = (r_state == ST_PACKET) && s_tvalid[r_grant] && w_out_free;

  always_comb begin
    w_state_nxt = r_state;
    s_tready    = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = ST_PACKET;
      end
      ST_PACKET: begin
        s_tready[r_grant] = w_out_free;
        if (w_accept && w_sel_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The grant only moves in IDLE, so it doubles as the round-robin pointer between packets.
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state <= ST_IDLE;
      r_grant <= GW'(NIN - 1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_any) r_grant <= w_pick;
    end
  end

  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= '0;
    end else if (w_accept) begin
      m_tvalid <= 1'b1;
      m_tdata  <= w_sel_data;
      m_tlast  <= w_sel_last;
      m_tuser  <= w_sel_user;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  assign o_grant = r_grant;
  assign o_busy  = (r_state == ST_PACKET);
endmodule

// File: doc/axis_pkt_arbiter.md
AXIS_PKT_ARBITER -- requirements
Module: axis_pkt_arbiter

Interface
REQ-001 Parameters SHALL be: NIN, default 4, number of slave streams (2..8); DW, default 32, TDATA width (multiple of 8); UW, default 1, TUSER width.
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 i_aclk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_areset  in  1  asynchronous, active-high reset.
REQ-005 s_tvalid  in  NIN  per-input TVALID.
REQ-006 s_tready  out  NIN  per-input TREADY; at most one bit high at any time.
REQ-007 s_tdata  in  NIN*DW  per-input TDATA, input k at [k*DW +: DW].
REQ-008 s_tlast  in  NIN  per-input TLAST.
REQ-009 s_tuser  in  NIN*UW  per-input TUSER, input k at [k*UW +: UW].
REQ-010 m_tvalid, m_tready, m_tdata[DW], m_tlast, m_tuser[UW], with m_tready as the only input: master stream.
REQ-011 o_grant  out  $clog2(NIN)  index of current or last granted input.
REQ-012 o_busy  out  1  high while a packet is in progress (state PACKET).

Function
REQ-013 The arbiter SHALL be a two-state FSM: IDLE and PACKET.
REQ-014 In IDLE with any s_tvalid high, the FSM SHALL select the first valid input strictly after o_grant, in ascending index with wrap-around, load it into o_grant, and enter PACKET on the next edge.
REQ-015 In IDLE, all s_tready bits SHALL be 0, giving a one-cycle arbitration bubble per packet.
REQ-016 In PACKET, s_tready[o_grant] SHALL equal (!m_tvalid || m_tready), combinationally; all other bits SHALL be 0.
REQ-017 Beat acceptance on the granted input SHALL register tdata, tlast and tuser into the m_* registers and set m_tvalid on the next edge (latency 1 cycle).
REQ-018 When m_tvalid && m_tready occur without a new accepted beat, m_tvalid SHALL clear on the next edge.
REQ-019 While m_tvalid && !m_tready, m_tdata, m_tlast and m_tuser SHALL be held stable.
REQ-020 Acceptance of a beat with s_tlast high SHALL return the FSM to IDLE on the same edge; o_grant SHALL be retained as the round-robin pointer.
REQ-021 A grant SHALL NOT change mid-packet, regardless of other inputs' s_tvalid.
REQ-022 When only one input requests, it SHALL be re-granted after each packet, with one bubble cycle between packets.
REQ-023 Throughput within a packet SHALL be one beat per cycle while m_tready is held high.
REQ-024 Single-beat packets (tlast on the first beat) SHALL be supported.
REQ-025 Deassertion of s_tvalid by the granted input mid-packet SHALL NOT change state; the FSM SHALL wait in PACKET.

Reset
REQ-026 On i_areset, the following SHALL be forced immediately and asynchronously: state IDLE, m_tvalid 0, m_tdata 0, m_tlast 0, m_tuser 0, o_grant NIN-1 (so input 0 has first priority), o_busy 0, s_tready all 0.
REQ-027 On reset asserted mid-packet, the packet SHALL be abandoned, any pending output beat dropped, and no partial state retained.
REQ-028 After reset release, the first arbitration SHALL occur on the first edge with i_areset low and any s_tvalid high.

Structure
REQ-029 No shared package SHALL be used; state encodings and the grant width SHALL be local parameters.
REQ-030 The round-robin selection SHALL be a combinational sub-module, axis_rr_pick, with inputs (request vector, last index) and outputs (next index, any-request).
REQ-031 Implementation SHALL be 120-400 lines of synthesizable Verilog, with no latches and no multiple drivers.

Verification
REQ-032 The bench SHALL cover this scenario: reset, then s_tvalid=4'b0001 with a 3-beat packet 0xA0,0xA1,0xA2 and m_tready=1 -> o_grant=0 after one bubble; m_tdata shows A0,A1,A2 on consecutive cycles; m_tlast is set on A2; o_busy then drops.
REQ-033 The bench SHALL cover this scenario: all four inputs continuously valid with 2-beat packets -> grant order 0,1,2,3,0; each packet is contiguous; one idle cycle separates packets.
REQ-034 The bench SHALL cover this scenario: m_tready held 0 for 5 cycles mid-packet -> m_tvalid stays 1, m_tdata stays stable, and s_tready[grant] stays 0 throughout.
REQ-035 The bench SHALL cover this scenario: i_areset pulsed during beat 2 of a 4-beat packet from input 2 -> m_tvalid drops immediately, o_grant=3, and the next grant goes to the lowest valid index.
REQ-036 The bench SHALL cover this scenario: input 1 sends single-beat packets while input 3 is valid -> grants alternate 1,3,1,3.
REQ-037 A formal harness SHALL bind AXI-Stream slave properties to each s_* port and master properties to the m_* port.
REQ-038 The formal harness SHALL assert onehot0(s_tready) and the stability of m_* while m_tvalid && !m_tready.
